light_ctrl_multi: RTL and testbench

// - N-channel automatic/manual lighting controller. Each channel has its own button, presence (IR) sensor, lamp output and manual LED.
// - Button press timing, the auto-off timeout and a shared millisecond prescaler are internal, so no external timer block is needed.
// - Sits between the synchronised panel/sensor inputs and the lamp drivers.

---
 rtl/light_ctrl_multi.sv | 180 ++++++++++++++++++
 tb/tb_light_ctrl_multi.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/light_ctrl_multi.sv
// N-channel automatic/manual lighting controller with a shared 1 ms prescaler.
// Optional global force-off input enabled by defining ALL_OFF_EN.
module light_ctrl_multi #(
   parameter int N_CH          = 4,
   parameter int TICK_DIV      = 50000,
   parameter int T_SHORT_MS    = 300,
   parameter int T_LONG_MS     = 5000,
   parameter int T_AUTO_OFF_MS = 30000
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [N_CH-1:0] btn,
   input  logic [N_CH-1:0] infra,
`ifdef ALL_OFF_EN
   input  logic            all_off,
`endif
   output logic [N_CH-1:0] lamp,
   output logic [N_CH-1:0] manual_led,
   output logic [N_CH-1:0] timer_active
);

   if (N_CH < 1) begin : g_chk_nch
      $error("light_ctrl_multi: N_CH must be >= 1");
   end
   if (TICK_DIV < 2) begin : g_chk_div
      $error("light_ctrl_multi: TICK_DIV must be >= 2");
   end
   if (T_LONG_MS <= T_SHORT_MS + 1) begin : g_chk_long
      $error("light_ctrl_multi: T_LONG_MS must exceed T_SHORT_MS+1");
   end
   if (T_AUTO_OFF_MS < 1) begin : g_chk_auto
      $error("light_ctrl_multi: T_AUTO_OFF_MS must be >= 1");
   end

   localparam int PRE_W   = $clog2(TICK_DIV);
   localparam int PRESS_W = $clog2(T_LONG_MS + 1);
   localparam int OFF_W   = $clog2(T_AUTO_OFF_MS + 1);

   localparam logic [PRE_W-1:0]   PRE_LAST = PRE_W'(TICK_DIV - 1);
   localparam logic [PRESS_W-1:0] LONG_T   = PRESS_W'(T_LONG_MS);
   localparam logic [PRESS_W-1:0] LONG_M1  = PRESS_W'(T_LONG_MS - 1);
   localparam logic [PRESS_W-1:0] SHORT_T  = PRESS_W'(T_SHORT_MS);
   localparam logic [OFF_W-1:0]   AUTO_M1  = OFF_W'(T_AUTO_OFF_MS - 1);

   typedef enum logic [1:0] {
      OFF_AUTO = 2'd0,
      ON_AUTO  = 2'd1,
      OFF_MAN  = 2'd2,
      ON_MAN   = 2'd3
   } state_t;

   logic [PRE_W-1:0]   pre_cnt_q, pre_cnt_d;
   logic               tick;
   logic [N_CH-1:0]    btn_q;
   logic               force_off;

   state_t             state_q     [N_CH];
   state_t             state_d     [N_CH];
   logic [PRESS_W-1:0] press_cnt_q [N_CH];
   logic [PRESS_W-1:0] press_cnt_d [N_CH];
   logic [OFF_W-1:0]   off_cnt_q   [N_CH];
   logic [OFF_W-1:0]   off_cnt_d   [N_CH];

   logic [N_CH-1:0]    long_ev;
   logic [N_CH-1:0]    short_ev;
   logic [N_CH-1:0]    timeout_ev;

`ifdef ALL_OFF_EN
   assign force_off = all_off;
`else
   assign force_off = 1'b0;
`endif

   assign tick = (pre_cnt_q == PRE_LAST);

   always_comb begin
      pre_cnt_d = tick ? '0 : pre_cnt_q + 1'b1;
   end

   always_comb begin
      long_ev    = '0;
      short_ev   = '0;
      timeout_ev = '0;
      for (int unsigned i = 0; i < N_CH; i++) begin
         state_d[i]     = state_q[i];
         press_cnt_d[i] = press_cnt_q[i];
         off_cnt_d[i]   = '0;

         long_ev[i]    = btn[i] & tick & (press_cnt_q[i] == LONG_M1);
         short_ev[i]   = ~btn[i] & btn_q[i] & (press_cnt_q[i] > SHORT_T)
                         & (press_cnt_q[i] < LONG_T);
         timeout_ev[i] = ~infra[i] & tick & (off_cnt_q[i] == AUTO_M1);

         // saturation at T_LONG_MS guarantees a single long event per press
         if (!btn[i]) begin
            press_cnt_d[i] = '0;
         end else if (tick && (press_cnt_q[i] < LONG_T)) begin
            press_cnt_d[i] = press_cnt_q[i] + 1'b1;
         end

         case (state_q[i])
            OFF_AUTO: begin
               if (long_ev[i])       state_d[i] = OFF_MAN;
               else if (infra[i])    state_d[i] = ON_AUTO;
            end
            ON_AUTO: begin
               if (long_ev[i])         state_d[i] = OFF_MAN;
               else if (timeout_ev[i]) state_d[i] = OFF_AUTO;
            end
            OFF_MAN: begin
               if (long_ev[i])       state_d[i] = ON_AUTO;
               else if (short_ev[i]) state_d[i] = ON_MAN;
            end
            ON_MAN: begin
               if (long_ev[i])       state_d[i] = ON_AUTO;
               else if (short_ev[i]) state_d[i] = OFF_MAN;
            end
            default: state_d[i] = OFF_AUTO;
         endcase

         // only a channel staying in ON_AUTO keeps its count; entry starts at 0
         if ((state_q[i] == ON_AUTO) && (state_d[i] == ON_AUTO)) begin
            if (infra[i])  off_cnt_d[i] = '0;
            else if (tick) off_cnt_d[i] = off_cnt_q[i] + 1'b1;
            else           off_cnt_d[i] = off_cnt_q[i];
         end

         if (force_off) begin
            state_d[i]     = OFF_AUTO;
            press_cnt_d[i] = '0;
            off_cnt_d[i]   = '0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pre_cnt_q <= '0;
         btn_q     <= '0;
         for (int unsigned i = 0; i < N_CH; i++) begin
            state_q[i]     <= OFF_AUTO;
            press_cnt_q[i] <= '0;
            off_cnt_q[i]   <= '0;
         end
      end else begin
         pre_cnt_q <= pre_cnt_d;
         btn_q     <= btn;
         for (int unsigned i = 0; i < N_CH; i++) begin
            state_q[i]     <= state_d[i];
            press_cnt_q[i] <= press_cnt_d[i];
            off_cnt_q[i]   <= off_cnt_d[i];
         end
      end
   end

   always_comb begin
      lamp         = '0;
      manual_led   = '0;
      timer_active = '0;
      for (int unsigned i = 0; i < N_CH; i++) begin
         case (state_q[i])
            ON_AUTO: begin
               lamp[i]         = 1'b1;
               timer_active[i] = 1'b1;
            end
            OFF_MAN: begin
               manual_led[i]   = 1'b1;
            end
            ON_MAN: begin
               lamp[i]         = 1'b1;
               manual_led[i]   = 1'b1;
            end
            default: begin
               lamp[i]         = 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_light_ctrl_multi.sv
// Bench for light_ctrl_multi: directed scenarios plus random stimulus against a
// mode/timer model; define ALL_OFF_EN to cover the force-off input.
module tb_light_ctrl_multi;

   localparam int NCH     = 2;
   localparam int DIV     = 4;
   localparam int T_SHORT = 3;
   localparam int T_LONG  = 10;
   localparam int T_AUTO  = 6;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic [NCH-1:0] btn = '0;
   logic [NCH-1:0] infra = '0;
   logic           aoff = 1'b0;
   logic [NCH-1:0] lamp, manual_led, timer_active;

   int n_cmp = 0;
   int n_err = 0;
   bit chk_en = 1'b0;

   light_ctrl_multi #(
      .N_CH(NCH), .TICK_DIV(DIV), .T_SHORT_MS(T_SHORT),
      .T_LONG_MS(T_LONG), .T_AUTO_OFF_MS(T_AUTO)
   ) dut (
      .clk(clk),
      .rst(rst),
      .btn(btn),
      .infra(infra),
`ifdef ALL_OFF_EN
      .all_off(aoff),
`endif
      .lamp(lamp),
      .manual_led(manual_led),
      .timer_active(timer_active)
   );

   always #5 clk = ~clk;

   // Model: per channel a "manual" flag, an "on" flag, the held-button length
   // in ms and the presence-free length in ms while auto-on.
   int pre_m;
   int held_m  [NCH];
   int quiet_m [NCH];
   bit prev_m  [NCH];
   bit man_m   [NCH];
   bit on_m    [NCH];

   always @(posedge clk) begin
      bit tk, lg, sh;
      if (rst) begin
         pre_m = 0;
         for (int c = 0; c < NCH; c++) begin
            held_m[c] = 0; quiet_m[c] = 0; prev_m[c] = 0; man_m[c] = 0; on_m[c] = 0;
         end
      end else begin
         tk = (pre_m == DIV - 1);
         pre_m = tk ? 0 : pre_m + 1;
         for (int c = 0; c < NCH; c++) begin
            lg = btn[c] && tk && (held_m[c] == T_LONG - 1);
            sh = !btn[c] && prev_m[c] && (held_m[c] > T_SHORT) && (held_m[c] < T_LONG);
            prev_m[c] = btn[c];
            if (!btn[c]) held_m[c] = 0;
            else if (tk && held_m[c] < T_LONG) held_m[c] = held_m[c] + 1;
            if (aoff) begin
               man_m[c] = 0; on_m[c] = 0; held_m[c] = 0; quiet_m[c] = 0;
            end else if (lg) begin
               on_m[c]  = man_m[c];
               man_m[c] = !man_m[c];
               quiet_m[c] = 0;
            end else if (man_m[c]) begin
               if (sh) on_m[c] = !on_m[c];
            end else if (!on_m[c]) begin
               if (infra[c]) begin on_m[c] = 1; quiet_m[c] = 0; end
            end else begin
               if (infra[c]) quiet_m[c] = 0;
               else if (tk) begin
                  if (quiet_m[c] == T_AUTO - 1) begin on_m[c] = 0; quiet_m[c] = 0; end
                  else quiet_m[c] = quiet_m[c] + 1;
               end
            end
         end
      end
   end

   task automatic check(input string name, input logic [NCH-1:0] act, input logic [NCH-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %b, expected %b", name, $time, act, exp);
      end
   endtask

   always @(negedge clk) begin
      logic [NCH-1:0] e_l, e_m, e_t;
      if (chk_en) begin
         for (int c = 0; c < NCH; c++) begin
            e_l[c] = on_m[c];
            e_m[c] = man_m[c];
            e_t[c] = on_m[c] && !man_m[c];
         end
         check("model lamp", lamp, e_l);
         check("model manual_led", manual_led, e_m);
         check("model timer_active", timer_active, e_t);
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic pin(input string name, input logic [NCH-1:0] l, input logic [NCH-1:0] m,
                      input logic [NCH-1:0] t);
      check({name, " lamp"}, lamp, l);
      check({name, " manual_led"}, manual_led, m);
      check({name, " timer_active"}, timer_active, t);
   endtask

   initial begin
      cyc(3);
      chk_en = 1'b1;
      rst = 1'b0;
      cyc(50);
      pin("idle", 2'b00, 2'b00, 2'b00);

      // presence pulse on ch0, then timeout within 21..24 edges of entry
      infra[0] = 1'b1; cyc(1); infra[0] = 1'b0;
      pin("auto on", 2'b01, 2'b00, 2'b01);
      cyc(19);
      pin("auto before timeout", 2'b01, 2'b00, 2'b01);
      cyc(4);
      pin("auto after timeout", 2'b00, 2'b00, 2'b00);

      // long press ch1 -> OFF_MAN, short -> ON_MAN, too-short -> nothing
      btn[1] = 1'b1; cyc(48);
      pin("long press", 2'b00, 2'b10, 2'b00);
      btn[1] = 1'b0; cyc(4);
      pin("long release", 2'b00, 2'b10, 2'b00);
      btn[1] = 1'b1; cyc(20); btn[1] = 1'b0; cyc(2);
      pin("short press", 2'b10, 2'b10, 2'b00);
      btn[1] = 1'b1; cyc(8); btn[1] = 1'b0; cyc(4);
      pin("too short", 2'b10, 2'b10, 2'b00);

      // presence refresh keeps ch0 on; ch1 manual ignores nothing here
      for (int k = 0; k < 5; k++) begin
         infra[0] = 1'b1; cyc(1); infra[0] = 1'b0; cyc(15);
      end
      pin("refresh", 2'b11, 2'b10, 2'b01);
      cyc(10);
      pin("refresh drop", 2'b10, 2'b10, 2'b00);

      // ON_MAN long -> ON_AUTO on ch1, then reset in the middle of a ch0 press
      btn[1] = 1'b1; cyc(44);
      pin("man to auto", 2'b10, 2'b00, 2'b10);
      btn[1] = 1'b0;
      btn[0] = 1'b1; cyc(10);
      rst = 1'b1; cyc(1);
      pin("reset mid press", 2'b00, 2'b00, 2'b00);
      rst = 1'b0; cyc(8); btn[0] = 1'b0; cyc(4);
      pin("held through reset", 2'b00, 2'b00, 2'b00);

`ifdef ALL_OFF_EN
      btn[0] = 1'b1; cyc(44); btn[0] = 1'b0; cyc(4);
      btn[0] = 1'b1; cyc(20); btn[0] = 1'b0; cyc(2);
      pin("ch0 on man", 2'b01, 2'b01, 2'b00);
      infra[1] = 1'b1; cyc(1);
      pin("ch1 auto", 2'b11, 2'b01, 2'b10);
      btn[0] = 1'b1; cyc(36);
      aoff = 1'b1; cyc(8);
      aoff = 1'b0; infra[1] = 1'b0; btn[0] = 1'b0; cyc(1);
      pin("all_off", 2'b00, 2'b00, 2'b00);
`endif

      for (int n = 0; n < 3000; n++) begin
         for (int c = 0; c < NCH; c++) begin
            if ($urandom_range(29) == 0) btn[c] = ~btn[c];
            infra[c] = ($urandom_range(59) == 0);
         end
         rst = ($urandom_range(1499) == 0);
`ifdef ALL_OFF_EN
         aoff = ($urandom_range(499) == 0);
`endif
         cyc(1);
      end
      rst = 1'b0; btn = '0; infra = '0; aoff = 1'b0;
      cyc(2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
